// File: rtl/arb_pkg.sv
// Shared types and sizing constants for the 4-way round-robin arbiter.
// The grant-length limit MAX_HOLD only takes effect when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating priority encoder: returns the first set request bit,
// searching ptr, ptr+1, ... modulo 4.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  // Walk the four positions starting at ptr; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    pick_idx = '0;
    pick_vld = |req;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter sharing one resource among 4 requesters.
// Grants are held until the owner drops its request or en falls; every grant is
// followed by at least one idle cycle, after which priority rotates past the owner.
// Optional feature: define ARB_TIMEOUT_EN to bound grants to MAX_HOLD cycles and
// pulse timeout when a grant is forcibly revoked.
module rr_arbiter_4
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  arb_state_t       state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q,  timeout_d;
`endif

  rr_pick_4 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // Next-state logic for the IDLE/GRANT FSM and all registered outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          state_d   = GRANT;
          gnt_d     = N_REQ'(1) << pick_idx;
          gnt_idx_d = pick_idx;
          gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        // Normal release is checked first so it wins over a same-edge timeout.
        if (!en || !req[gnt_idx_q]) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        // hold_cnt counts completed grant cycles minus one, so MAX_HOLD-1 means
        // the grant has now been visible for MAX_HOLD cycles.
        else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
